// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling ratios, parity encodings.
// Also used by the TX side for parity type.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_typ_e;

    // Unsupported ratios fall back to the slowest-to-break setting of 8.
    function automatic logic [5:0] decode_prescale(input logic [5:0] raw);
        case (raw)
            PRESCALE_16: return PRESCALE_16;
            PRESCALE_32: return PRESCALE_32;
            default:     return PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// System-side bundle of the UART receiver: serial line, frame configuration, results.
// master drives the line and configuration; slave is the receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Three-point majority sampler around the centre of an oversampled bit period.
// The voted bit is stable from edge_cnt = P/2+1 until the next period's samples.
module uart_rx_sampler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_s_i,
    input  logic [5:0] edge_cnt_i,
    input  logic [5:0] prescale_i,
    output logic       bit_o
);
    logic [5:0] half;
    logic [2:0] samples_q, samples_d;

    assign half = prescale_i >> 1;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        samples_d = samples_q;
        if (edge_cnt_i == half - 6'd2) samples_d[0] = rx_s_i;
        if (edge_cnt_i == half - 6'd1) samples_d[1] = rx_s_i;
        if (edge_cnt_i == half)        samples_d[2] = rx_s_i;
    end

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!RST) samples_q <= 3'b111;
        else      samples_q <= samples_d;
    end

    assign bit_o = (samples_q[0] & samples_q[1]) |
                   (samples_q[0] & samples_q[2]) |
                   (samples_q[1] & samples_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, qualifies the start bit, deserializes LSB-first data,
// checks optional parity and the stop bit, and reports one-cycle result strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave bus
);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    logic rx_meta_q, rx_s_q;

    rx_state_e             state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [5:0]            prescale_q, prescale_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_mis_q, par_mis_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic sampled_bit;
    logic edge_last;

    // NOTE: synchronizer flops reset to 1 so an idle-high line never looks like a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    uart_rx_sampler u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .rx_s_i     (rx_s_q),
        .edge_cnt_i (edge_cnt_q),
        .prescale_i (prescale_q),
        .bit_o      (sampled_bit)
    );

    assign edge_last = (edge_cnt_q == prescale_q - 6'd1);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_last ? 6'd0 : edge_cnt_q + 6'd1;
        prescale_d   = prescale_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = 6'd0;
                if (!rx_s_q) begin
                    state_d    = ST_START;
                    prescale_d = decode_prescale(bus.Prescale);
                    par_mis_d  = 1'b0;
                    bit_cnt_d  = '0;
                end
            end

            ST_START: begin
                if (edge_last) begin
                    bit_cnt_d = '0;
                    state_d   = sampled_bit ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (edge_last) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = bus.PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (edge_last) begin
                    par_mis_d = sampled_bit != ((^shift_q) ^ (bus.PAR_TYP == PAR_ODD));
                    state_d   = ST_STOP;
                end
            end

            ST_STOP: begin
                if (edge_last) begin
                    if (sampled_bit && !par_mis_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    par_err_d = par_mis_q;
                    stp_err_d = !sampled_bit;
                    // A low line here is already the next start bit.
                    if (!rx_s_q) begin
                        state_d    = ST_START;
                        prescale_d = decode_prescale(bus.Prescale);
                        par_mis_d  = 1'b0;
                        bit_cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= 6'd0;
            prescale_q   <= PRESCALE_8;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            prescale_q   <= prescale_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_mis_q    <= par_mis_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialized onto RX_IN, expected results are queued,
// and a negedge monitor pops and compares each strobe, including its exact cycle.
module tb_uart_rx;
    import uart_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       se;
        int         cyc;
    } exp_t;

    typedef enum {K_OK, K_PAR, K_STP, K_BOTH} kind_e;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called #1 after a rising edge; leaves the line high and returns at the same phase.
    task automatic send_frame(input logic [7:0] data, input int p, input logic par_en,
                              input logic par_typ, input kind_e kind, input int glitch_bit);
        exp_t e;
        logic par_bit;
        logic stop_bit;
        par_bit  = (^data) ^ par_typ;
        if (kind == K_PAR || kind == K_BOTH) par_bit = ~par_bit;
        stop_bit = !(kind == K_STP || kind == K_BOTH);
        e.dv = (kind == K_OK);
        e.pe = (kind == K_PAR || kind == K_BOTH);
        e.se = (kind == K_STP || kind == K_BOTH);
        if (e.dv) last_good = data;
        e.data = last_good;
        e.cyc  = cyc + 3 + (10 + int'(par_en)) * p;
        sb.push_back(e);

        bus.RX_IN = 1'b0;
        hold(p);
        for (int i = 0; i < 8; i++) begin
            bus.RX_IN = data[i];
            if (i == glitch_bit) begin
                hold(p / 2);
                bus.RX_IN = ~data[i];
                hold(1);
                bus.RX_IN = data[i];
                hold(p - p / 2 - 1);
            end else begin
                hold(p);
            end
        end
        if (par_en) begin
            bus.RX_IN = par_bit;
            hold(p);
        end
        bus.RX_IN = stop_bit;
        hold(p);
        bus.RX_IN = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) hold(1);
        check(tag, sb.size(), 0);
        hold(4);
    endtask

    always @(negedge CLK) begin
        if (RST && (bus.data_valid || bus.par_err || bus.stp_err)) begin
            check("strobe_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("strobes{dv,pe,se}", {bus.data_valid, bus.par_err, bus.stp_err},
                      {e.dv, e.pe, e.se});
                check("P_DATA", bus.P_DATA, e.data);
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        RST          = 1'b0;
        #2;
        check("rst_P_DATA", bus.P_DATA, 8'h00);
        check("rst_data_valid", bus.data_valid, 0);
        check("rst_par_err", bus.par_err, 0);
        check("rst_stp_err", bus.stp_err, 0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        hold(4);

        // P=8, no parity, 0xA5: 83 cycles to data_valid
        send_frame(8'hA5, 8, 1'b0, 1'b0, K_OK, -1);
        drain("drain_a5");

        // P=16 even parity: good then bad parity bit
        bus.Prescale = 6'd16;
        bus.PAR_EN   = 1'b1;
        bus.PAR_TYP  = PAR_EVEN;
        send_frame(8'h3C, 16, 1'b1, 1'b0, K_OK, -1);
        drain("drain_3c_good");
        send_frame(8'h3C, 16, 1'b1, 1'b0, K_PAR, -1);
        drain("drain_3c_parerr");
        bus.PAR_TYP = PAR_ODD;
        send_frame(8'h96, 16, 1'b1, 1'b1, K_OK, -1);
        drain("drain_96_odd");

        // P=8 both parity and stop errors together
        bus.Prescale = 6'd8;
        bus.PAR_TYP  = PAR_EVEN;
        send_frame(8'h7E, 8, 1'b1, 1'b0, K_BOTH, -1);
        drain("drain_7e_both");

        // P=8 stop error, then recovery; Prescale=12 must behave as 8
        bus.PAR_EN = 1'b0;
        send_frame(8'h55, 8, 1'b0, 1'b0, K_STP, -1);
        drain("drain_55_stperr");
        hold(24);
        check("idle_after_stperr", 32'(dut.state_q), 32'(ST_IDLE));
        bus.Prescale = 6'd12;
        send_frame(8'h12, 8, 1'b0, 1'b0, K_OK, -1);
        drain("drain_12");

        // P=16 short start glitch, then a centre-sample glitch on bit 0
        bus.Prescale = 6'd16;
        bus.RX_IN    = 1'b0;
        hold(3);
        bus.RX_IN = 1'b1;
        hold(40);
        check("idle_after_start_glitch", 32'(dut.state_q), 32'(ST_IDLE));
        check("no_pending_after_glitch", sb.size(), 0);
        send_frame(8'h81, 16, 1'b0, 1'b0, K_OK, 0);
        drain("drain_81_glitch");

        // P=32 back-to-back frames, no idle gap
        bus.Prescale = 6'd32;
        send_frame(8'h01, 32, 1'b0, 1'b0, K_OK, -1);
        send_frame(8'hFF, 32, 1'b0, 1'b0, K_OK, -1);
        drain("drain_b2b");

        // Reset in the middle of DATA of a P=8 frame
        bus.Prescale = 6'd8;
        bus.RX_IN    = 1'b0;
        hold(8);
        bus.RX_IN = 1'b1;
        hold(12);
        check("state_before_midreset", 32'(dut.state_q), 32'(ST_DATA));
        RST = 1'b0;
        #1;
        last_good = 8'h00;
        check("midrst_P_DATA", bus.P_DATA, 8'h00);
        check("midrst_data_valid", bus.data_valid, 0);
        check("midrst_par_err", bus.par_err, 0);
        check("midrst_stp_err", bus.stp_err, 0);
        check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(posedge CLK);
        #1;
        RST = 1'b1;
        hold(10);
        send_frame(8'hC3, 8, 1'b0, 1'b0, K_OK, -1);
        drain("drain_c3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
